// File: rtl/rv32i_selftest_sequencer_pkg.sv
// Shared types for the RV32I self-test sequencer:
// sequencer states, regfile index width and run-phase status.
package rv32i_selftest_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CHECK,
        DONE
    } seq_state_e;

    typedef enum logic [1:0] {
        RUN_GO,
        RUN_HALT,
        RUN_TIMEOUT
    } run_status_e;

endpackage

// File: rtl/rv32i_selftest_sequencer_if.sv
// Program-load and register-check handshake bundle
// between a test source (master) and the sequencer (slave).
interface rv32i_selftest_sequencer_if
    import rv32i_selftest_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                 prog_valid;
    logic                 prog_ready;
    logic [XLEN-1:0]      prog_data;
    logic                 prog_last;
    logic                 chk_valid;
    logic                 chk_ready;
    logic [REG_IDX_W-1:0] chk_idx;
    logic [XLEN-1:0]      chk_data;
    logic                 chk_last;

    modport master (
        output prog_valid, prog_data, prog_last,
        output chk_valid, chk_idx, chk_data, chk_last,
        input  prog_ready, chk_ready
    );

    modport slave (
        input  prog_valid, prog_data, prog_last,
        input  chk_valid, chk_idx, chk_data, chk_last,
        output prog_ready, chk_ready
    );
endinterface

// File: rtl/rv32i_selftest_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && count != {W{1'b1}}) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/rv32i_selftest_sequencer.sv
// Self-test controller: loads IMEM, runs the core to a halt PC
// or cycle budget, then checks regfile values and reports status.
module rv32i_selftest_sequencer
    import rv32i_selftest_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int IMEM_DEPTH = 64,
    parameter int CYC_W      = 16,
    parameter int ERR_W      = 8,
    localparam int AW        = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    rv32i_selftest_sequencer_if.slave bus,
    output logic                 imem_we,
    output logic [AW-1:0]        imem_addr,
    output logic [XLEN-1:0]      imem_wdata,
    output logic                 core_rst,
    output logic                 core_stall,
    input  logic [XLEN-1:0]      core_pc,
    input  logic [XLEN-1:0]      halt_pc,
    input  logic [CYC_W-1:0]     cycle_budget,
    output logic [REG_IDX_W-1:0] rf_raddr,
    input  logic [XLEN-1:0]      rf_rdata,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_W-1:0]     err_count,
    output logic [CYC_W-1:0]     cycles_used
);
    seq_state_e  state_q;
    seq_state_e  state_d;
    run_status_e run_st;

    logic [AW-1:0]  addr_q;
    logic [CYC_W:0] budget_ext;
    logic [CYC_W:0] cyc_next;
    logic prog_hs;
    logic chk_hs;
    logic at_end;
    logic trunc;
    logic mismatch;
    logic start_ok;
    logic pc_halt;

    assign prog_hs  = bus.prog_valid & bus.prog_ready;
    assign chk_hs   = bus.chk_valid & bus.chk_ready;
    assign at_end   = addr_q == AW'(IMEM_DEPTH - 1);
    assign trunc    = prog_hs & at_end & ~bus.prog_last;
    assign mismatch = chk_hs & (rf_rdata != bus.chk_data);
    assign start_ok = start & (state_q == IDLE || state_q == DONE);
    assign pc_halt  = core_pc == halt_pc;

    // A zero budget stands for the full 2^CYC_W range.
    assign budget_ext = (cycle_budget == '0)
                      ? {1'b1, {CYC_W{1'b0}}}
                      : {1'b0, cycle_budget};
    assign cyc_next   = {1'b0, cycles_used} + (CYC_W+1)'(1);

    // Halt takes priority over budget expiry.
    always_comb begin
        run_st = RUN_GO;
        if (pc_halt) begin
            run_st = RUN_HALT;
        end else if (cyc_next == budget_ext) begin
            run_st = RUN_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = LOAD;
            LOAD:  if (prog_hs && (bus.prog_last || at_end)) state_d = RUN;
            RUN:   if (run_st != RUN_GO) state_d = CHECK;
            CHECK: if (chk_hs && bus.chk_last) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.prog_ready = 1'b0;
        bus.chk_ready  = 1'b0;
        core_rst       = 1'b0;
        core_stall     = 1'b1;
        unique case (state_q)
            IDLE: core_rst = 1'b1;
            LOAD: begin
                core_rst       = 1'b1;
                bus.prog_ready = 1'b1;
            end
            RUN:   core_stall    = pc_halt;
            CHECK: bus.chk_ready = 1'b1;
            DONE:  core_stall    = 1'b1;
            default: core_rst    = 1'b1;
        endcase
    end

    assign imem_we    = prog_hs;
    assign imem_addr  = addr_q;
    assign imem_wdata = bus.prog_data;
    assign rf_raddr   = bus.chk_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            cycles_used <= '0;
            timeout     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else if (start_ok) begin
            addr_q      <= '0;
            cycles_used <= '0;
            timeout     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            if (prog_hs) begin
                addr_q <= addr_q + AW'(1);
            end
            if (state_q == RUN && !pc_halt) begin
                cycles_used <= cycles_used + CYC_W'(1);
            end
            if (state_q == RUN && run_st == RUN_TIMEOUT) begin
                timeout <= 1'b1;
            end
            if (state_q == CHECK && chk_hs && bus.chk_last) begin
                done <= 1'b1;
                pass <= (err_count == '0) && !mismatch && !timeout;
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err (
        .clk   (clk),
        .rst   (rst),
        .clear (start_ok),
        .inc   (trunc | mismatch),
        .count (err_count)
    );
endmodule

// File: tb/tb_rv32i_selftest_sequencer.sv
// Bench: behavioural core/IMEM around the sequencer, an ISA-level
// reference run per session, and per-cycle handshake/stall checks.
module tb_rv32i_selftest_sequencer;
    localparam int NPROG = 15;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // ---------------- main DUT ----------------
    rv32i_selftest_sequencer_if #(.XLEN(32)) bus ();
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        core_stall;
    logic [31:0] core_pc;
    logic [31:0] halt_pc;
    logic [15:0] cycle_budget;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [7:0]  err_count;
    logic [15:0] cycles_used;

    rv32i_selftest_sequencer #(.IMEM_DEPTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_stall(core_stall), .core_pc(core_pc),
        .halt_pc(halt_pc), .cycle_budget(cycle_budget), .rf_raddr(rf_raddr),
        .rf_rdata(rf_rdata), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .cycles_used(cycles_used)
    );

    // ---------------- small DUT for truncation ----------------
    rv32i_selftest_sequencer_if #(.XLEN(32)) bus8 ();
    logic        start8;
    logic        imem_we8;
    logic [2:0]  imem_addr8;
    logic [31:0] imem_wdata8;
    logic        core_rst8;
    logic        core_stall8;
    logic [31:0] core_pc8 = 32'h0;
    logic [31:0] halt_pc8 = 32'h0;
    logic [15:0] cycle_budget8 = 16'd10;
    logic [4:0]  rf_raddr8;
    logic [31:0] rf_rdata8 = 32'h0;
    logic        done8;
    logic        pass8;
    logic        timeout8;
    logic [7:0]  err8;
    logic [15:0] cyc8;
    logic [31:0] mem8 [8];
    int          nwr8 = 0;

    rv32i_selftest_sequencer #(.IMEM_DEPTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .bus(bus8),
        .imem_we(imem_we8), .imem_addr(imem_addr8), .imem_wdata(imem_wdata8),
        .core_rst(core_rst8), .core_stall(core_stall8), .core_pc(core_pc8),
        .halt_pc(halt_pc8), .cycle_budget(cycle_budget8), .rf_raddr(rf_raddr8),
        .rf_rdata(rf_rdata8), .done(done8), .pass(pass8), .timeout(timeout8),
        .err_count(err8), .cycles_used(cyc8)
    );

    always @(posedge clk) if (imem_we8) begin
        mem8[imem_addr8] <= imem_wdata8;
        nwr8 = nwr8 + 1;
    end

    // ---------------- ISA helpers ----------------
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, rs1,
                                             input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction
    function automatic logic [31:0] enc_add(input logic [4:0] rd, rs1, rs2);
        return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, rs2,
                                            input logic [12:0] off);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'h63};
    endfunction

    function automatic void iss(input logic [31:0] ins, pc, a, b,
                                output logic we, output logic [4:0] rd,
                                output logic [31:0] wv, output logic [31:0] npc);
        logic [31:0] bimm;
        bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        we = 1'b0; rd = ins[11:7]; wv = '0; npc = pc + 32'd4;
        case (ins[6:0])
            7'h13: begin we = (ins[14:12] == 3'b000); wv = a + {{20{ins[31]}}, ins[31:20]}; end
            7'h33: begin we = 1'b1; wv = a + b; end
            7'h63: if (a == b) npc = pc + bimm;
            default: ;
        endcase
    endfunction

    // ---------------- behavioural IMEM + core ----------------
    logic [31:0] imem [64];
    logic        clr_imem = 1'b0;
    logic [31:0] c_pc = 32'h0;
    logic [31:0] c_regs [32];
    logic [31:0] c_ins, c_wv, c_npc;
    logic [4:0]  c_rd;
    logic        c_we;

    always @(posedge clk) begin
        if (clr_imem) begin
            for (int i = 0; i < 64; i++) imem[i] <= '0;
        end else if (imem_we) begin
            imem[imem_addr] <= imem_wdata;
        end
    end

    always @(posedge clk) begin
        if (core_rst) begin
            c_pc <= '0;
            for (int r = 0; r < 32; r++) c_regs[r] <= '0;
        end else if (!core_stall) begin
            c_ins = imem[c_pc[7:2]];
            iss(c_ins, c_pc, c_regs[c_ins[19:15]], c_regs[c_ins[24:20]],
                c_we, c_rd, c_wv, c_npc);
            if (c_we && c_rd != 5'd0) c_regs[c_rd] <= c_wv;
            c_pc <= c_npc;
        end
    end

    assign core_pc  = c_pc;
    assign rf_rdata = c_regs[rf_raddr];

    // ---------------- program, checks, model ----------------
    logic [31:0] prog [64];
    logic [4:0]  ck_idx [8];
    logic [31:0] ck_val [8];
    int          n_ck;
    logic [31:0] m_regs [32];

    task automatic add_ck(input logic [4:0] idx, input logic [31:0] val);
        ck_idx[n_ck] = idx;
        ck_val[n_ck] = val;
        n_ck++;
    endtask

    task automatic set_s1_checks(input logic [31:0] x3);
        n_ck = 0;
        add_ck(5'd1, 32'h5);
        add_ck(5'd2, 32'hA);
        add_ck(5'd3, x3);
        add_ck(5'd8, 32'hF);
        add_ck(5'd10, 32'h64);
    endtask

    // Architectural reference run: executes instructions until the halt PC
    // or until the budget-th instruction has retired.
    task automatic model_run(input logic [31:0] hp, input int budget,
                             output int cyc, output bit to, output int errs);
        logic [31:0] pc, wv, npc, ins;
        logic [4:0]  rd;
        logic        we;
        int          lim;
        lim = (budget == 0) ? 65536 : budget;
        for (int r = 0; r < 32; r++) m_regs[r] = '0;
        pc = '0; cyc = 0; to = 1'b0;
        while (pc != hp && !to) begin
            ins = prog[pc[7:2]];
            iss(ins, pc, m_regs[ins[19:15]], m_regs[ins[24:20]], we, rd, wv, npc);
            if (we && rd != 5'd0) m_regs[rd] = wv;
            pc = npc;
            cyc++;
            if (cyc == lim) to = 1'b1;
        end
        errs = 0;
        for (int j = 0; j < n_ck; j++)
            if (m_regs[ck_idx[j]] != ck_val[j]) errs++;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) if (!rst) begin
        check("imem_we", imem_we, bus.prog_valid & bus.prog_ready);
        if (imem_we) check("imem_wdata", imem_wdata, bus.prog_data);
        check("rf_raddr", rf_raddr, bus.chk_idx);
        check("ready_excl", bus.prog_ready & bus.chk_ready, 0);
        if (!core_rst && !done && !bus.chk_ready)
            check("run_stall", core_stall, core_pc == halt_pc);
        if (done) check("done_core", {core_rst, core_stall}, 2'b01);
    end

    // ---------------- session driver ----------------
    task automatic wait_ready(input bit on_chk, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (on_chk ? bus.chk_ready : bus.prog_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_session(input logic [31:0] hp, input int budget,
                               input bit gaps, input bit srun, input int abort_at);
        bit ok;
        halt_pc = hp;
        cycle_budget = 16'(budget);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < NPROG; i++) begin
            if (gaps && i % 2 == 1) begin
                bus.prog_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.prog_valid = 1'b1;
            bus.prog_data  = prog[i];
            bus.prog_last  = (i == NPROG - 1);
            wait_ready(1'b0, ok);
            if (!ok) begin check("prog_hs_bound", 0, 1); break; end
        end
        bus.prog_valid = 1'b0;
        bus.prog_last  = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (bus.chk_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            start = srun && (k % 3 == 1);
            if (abort_at > 0 && k == abort_at) begin
                start = 1'b0;
                rst = 1'b1;
                return;
            end
        end
        start = 1'b0;
        if (!ok) begin check("run_bound", 0, 1); return; end
        @(posedge clk); #1;
        for (int j = 0; j < n_ck; j++) begin
            if (gaps && j % 2 == 1) begin
                bus.chk_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.chk_valid = 1'b1;
            bus.chk_idx   = ck_idx[j];
            bus.chk_data  = ck_val[j];
            bus.chk_last  = (j == n_ck - 1);
            wait_ready(1'b1, ok);
            if (!ok) begin check("chk_hs_bound", 0, 1); break; end
        end
        bus.chk_valid = 1'b0;
        bus.chk_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic compare_results(input string tag, input logic [31:0] hp,
                                   input int budget);
        int cyc, errs;
        bit to;
        model_run(hp, budget, cyc, to, errs);
        check({tag, " done"}, done, 1);
        check({tag, " pass"}, pass, (errs == 0) && !to);
        check({tag, " err_count"}, err_count, errs);
        check({tag, " timeout"}, timeout, to);
        check({tag, " cycles"}, cycles_used, cyc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " core_rst"}, core_rst, 1);
        check({tag, " core_stall"}, core_stall, 1);
        check({tag, " prog_ready"}, bus.prog_ready, 0);
        check({tag, " chk_ready"}, bus.chk_ready, 0);
        check({tag, " imem_we"}, imem_we, 0);
        check({tag, " done"}, done, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " timeout"}, timeout, 0);
        check({tag, " err_count"}, err_count, 0);
        check({tag, " cycles"}, cycles_used, 0);
        check({tag, " imem_addr"}, imem_addr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  mcyc, merr;
        bit  mto, ok;

        for (int i = 0; i < 64; i++) prog[i] = enc_addi(5'd0, 5'd0, 12'd0);
        prog[0]  = enc_addi(5'd1, 5'd0, 12'd5);
        prog[5]  = enc_addi(5'd2, 5'd0, 12'd10);
        prog[6]  = enc_add(5'd3, 5'd1, 5'd2);
        prog[7]  = enc_addi(5'd8, 5'd3, 12'd0);
        prog[10] = enc_beq(5'd3, 5'd8, 13'd8);
        prog[11] = enc_addi(5'd10, 5'd0, 12'd1);
        prog[12] = enc_addi(5'd10, 5'd0, 12'd100);

        rst = 1'b1; start = 1'b0; start8 = 1'b0;
        bus.prog_valid = 0; bus.prog_data = '0; bus.prog_last = 0;
        bus.chk_valid = 0; bus.chk_idx = '0; bus.chk_data = '0; bus.chk_last = 0;
        bus8.prog_valid = 0; bus8.prog_data = '0; bus8.prog_last = 0;
        bus8.chk_valid = 0; bus8.chk_idx = '0; bus8.chk_data = '0; bus8.chk_last = 0;
        halt_pc = 32'h34; cycle_budget = 16'd100;

        check("enc_addi_x1_5", prog[0], 32'h00500093);
        check("enc_beq_x3_x8_8", prog[10], 32'h00818463);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Scenario 1: arithmetic program passes
        set_s1_checks(32'hF);
        model_run(32'h34, 100, mcyc, mto, merr);
        check("model_s1_cycles", mcyc, 12);
        check("model_s1_errs", merr, 0);
        run_session(32'h34, 100, 1'b0, 1'b0, 0);
        compare_results("s1", 32'h34, 100);
        check("s1 pass literal", pass, 1);
        check("s1 cycles literal", cycles_used, 12);
        @(posedge clk); #1;

        // Scenario 2: budget expiry
        n_ck = 0;
        add_ck(5'd1, 32'h5);
        add_ck(5'd3, 32'hF);
        run_session(32'h34, 5, 1'b0, 1'b0, 0);
        compare_results("s2", 32'h34, 5);
        check("s2 timeout literal", timeout, 1);
        check("s2 cycles literal", cycles_used, 5);
        check("s2 err literal", err_count, 1);
        check("s2 pass literal", pass, 0);
        @(posedge clk); #1;

        // Scenario 3a: wrong expectation for x3
        set_s1_checks(32'h10);
        run_session(32'h34, 100, 1'b0, 1'b0, 0);
        compare_results("s3a", 32'h34, 100);
        check("s3a err literal", err_count, 1);
        check("s3a pass literal", pass, 0);
        @(posedge clk); #1;

        // Scenario 3b: single x0 == 0 check
        n_ck = 0;
        add_ck(5'd0, 32'h0);
        run_session(32'h34, 100, 1'b0, 1'b0, 0);
        compare_results("s3b", 32'h34, 100);
        check("s3b err literal", err_count, 0);
        check("s3b pass literal", pass, 1);
        @(posedge clk); #1;

        // Scenario 4: load truncation at IMEM_DEPTH=8
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        bus8.prog_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus8.prog_data = 32'hA000_0000 + 32'(i);
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                @(negedge clk);
                ok = bus8.prog_ready;
                @(posedge clk); #1;
            end
            if (!ok) check("s4 prog_hs_bound", 0, 1);
        end
        @(negedge clk);
        check("s4 prog_ready", bus8.prog_ready, 0);
        check("s4 err", err8, 1);
        check("s4 writes", nwr8, 8);
        check("s4 core_rst", core_rst8, 0);
        check("s4 core_stall", core_stall8, 1);
        repeat (3) begin @(posedge clk); #1; end
        bus8.prog_valid = 1'b0;
        check("s4 writes held", nwr8, 8);
        check("s4 mem0", mem8[0], 32'hA000_0000);
        check("s4 mem7", mem8[7], 32'hA000_0007);
        bus8.chk_valid = 1'b1; bus8.chk_idx = 5'd0;
        bus8.chk_data = 32'h0; bus8.chk_last = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = bus8.chk_ready;
            if (ok) check("s4 rf_raddr", rf_raddr8, 0);
            @(posedge clk); #1;
        end
        if (!ok) check("s4 chk_hs_bound", 0, 1);
        bus8.chk_valid = 1'b0; bus8.chk_last = 1'b0;
        @(negedge clk);
        check("s4 done", done8, 1);
        check("s4 pass", pass8, 0);
        check("s4 err final", err8, 1);
        check("s4 timeout", timeout8, 0);
        check("s4 cycles", cyc8, 0);
        @(posedge clk); #1;

        // Scenario 5: reset mid-run, then a clean session
        set_s1_checks(32'hF);
        run_session(32'h34, 100, 1'b0, 1'b0, 4);
        #1;
        check_reset_outputs("s5 mid-run reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_session(32'h34, 100, 1'b0, 1'b0, 0);
        compare_results("s5", 32'h34, 100);
        check("s5 pass literal", pass, 1);
        @(posedge clk); #1;

        // Scenario 6: gapped valids and start pulses during RUN
        clr_imem = 1'b1;
        @(posedge clk); #1;
        clr_imem = 1'b0;
        set_s1_checks(32'hF);
        run_session(32'h34, 100, 1'b1, 1'b1, 0);
        compare_results("s6", 32'h34, 100);
        check("s6 cycles literal", cycles_used, 12);
        check("s6 pass literal", pass, 1);
        for (int i = 0; i < NPROG; i++) check("s6 imem", imem[i], prog[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rv32i_selftest_sequencer.md
# rv32i_selftest_sequencer

Synthesisable self-test controller for the RV32I single-cycle core. It streams a program into instruction memory, holds the core in reset while loading, then runs the core until it reaches a halt PC or a cycle budget expires. It then checks register-file contents against a stream of expected values and reports pass/fail. It replaces fixed-length, hard-coded simulation sequences with a parametrised, reusable block that can sit beside the core on an FPGA or in any bench.

## Interface
Parameters:
- XLEN, 32, data/PC width
- IMEM_DEPTH, 64, instruction-memory words (power of two, ≥2)
- CYC_W, 16, width of cycle budget/counter
- ERR_W, 8, width of saturating error counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin session; honoured only in IDLE or DONE
- prog_valid / prog_ready  in / out  1  program-word handshake
- prog_data  in  XLEN  instruction word
- prog_last  in  1  final program word
- imem_we  out  1  IMEM write strobe (= prog_valid & prog_ready)
- imem_addr  out  $clog2(IMEM_DEPTH)  word index
- imem_wdata  out  XLEN  = prog_data
- core_rst  out  1  core reset
- core_stall  out  1  freezes core PC and regfile/DMEM writes
- core_pc  in  XLEN  core's current PC
- halt_pc  in  XLEN  PC at which run ends (instruction not executed)
- cycle_budget  in  CYC_W  max executed instructions; 0 means 2^CYC_W
- chk_valid / chk_ready  in / out  1  expected-value handshake
- chk_idx  in  5  register index
- chk_data  in  XLEN  expected value
- chk_last  in  1  final check
- rf_raddr  out  5  regfile debug read address (= chk_idx)
- rf_rdata  in  XLEN  combinational regfile read data
- done, pass, timeout  out  1  status
- err_count  out  ERR_W  mismatches plus load truncation, saturating
- cycles_used  out  CYC_W  instructions executed in RUN

## Operation
States are IDLE, LOAD, RUN, CHECK and DONE.

- **IDLE:** core_rst=1, core_stall=1. On start, go to LOAD; clear word address, err_count, timeout, cycles_used, done and pass.
- **LOAD:** prog_ready=1, core_rst=1. Each handshake writes IMEM[addr] and increments addr.
  - Handshake with prog_last → RUN.
  - Handshake at addr==IMEM_DEPTH-1 without prog_last → RUN and err_count+1 (truncation). Further words are not accepted.
- **RUN:** core_rst=0. core_stall = (core_pc==halt_pc), combinational.
  - Each cycle with core_stall=0 increments cycles_used.
  - If core_pc==halt_pc → CHECK.
  - Else, if cycles_used reaches the budget on this edge → CHECK with timeout=1.
  - Halt match and budget expiry in the same cycle: halt wins; timeout stays 0.
- **CHECK:** core_stall=1, core_rst=0, so the architectural state is held. chk_ready=1. On each handshake, compare rf_rdata with chk_data and increment err_count on mismatch (saturate at 2^ERR_W-1). The handshake with chk_last → DONE.
- **DONE:** done=1, pass = (err_count==0 && !timeout); both registered. The core stays stalled. start → LOAD, which reasserts core_rst and re-clears status.
- start in LOAD, RUN or CHECK is ignored. The IMEM write port is used only in LOAD.

## Timing
- Reset values (async assert, any state):
  - state = IDLE
  - core_rst = 1, core_stall = 1
  - prog_ready = 0, chk_ready = 0, imem_we = 0
  - done = 0, pass = 0, timeout = 0
  - err_count = 0, cycles_used = 0, imem_addr = 0
- Handshake timing:
  - prog_ready and chk_ready are pure state decodes, with no combinational path from valid.
  - One word or check is accepted per cycle; gaps in valid are tolerated.
- start → LOAD one edge later. core_rst deasserts the cycle after the last-word edge.
- The instruction at halt_pc never executes: stall asserts in the same cycle the PC matches.
- Status outputs change on the edge entering DONE and hold until the next start or rst.
- rst mid-session aborts immediately; IMEM contents are left as they are.

## Structure
- Package rv32i_selftest_pkg holds:
  - the state enum (IDLE, LOAD, RUN, CHECK, DONE)
  - the regfile index width constant (5)
  - the halt/timeout status encoding
- One sub-module, sat_counter (parametrised width, inc, clear), is used for err_count. cycles_used is an ordinary counter.
- The core exposes a core_stall port and a regfile debug read port (rf_raddr/rf_rdata).

## Test plan
1. **Arithmetic program, pass case.**
   - Stimulus: the 15-word arithmetic/branch program (ADDI x1=5 … BEQ over 0x2C, ADDI x10=100 at 0x30, NOPs); halt_pc=0x34; budget=100; checks x1=5, x2=0xA, x3=0xF, x8=0xF, x10=0x64.
   - Response: done=1, pass=1, err_count=0, timeout=0, cycles_used=12.
2. **Budget expiry.** Same program with budget=5 → timeout=1, pass=0, cycles_used=5, x3 check fails (err_count=1).
3. **Register mismatch.** Expected x3=0x10 → err_count=1, pass=0; a single check of x0 against 0 adds no error.
4. **Load truncation.** With IMEM_DEPTH=8, stream 8 words without prog_last → enters RUN after the 8th, prog_ready=0, err_count=1.
5. **Reset mid-run.** Assert rst during RUN → all outputs at reset values in the same cycle. A fresh start then completes scenario 1 with pass=1.
6. **Backpressure and ignored start.** prog_valid and chk_valid toggle every other cycle and start pulses during RUN → identical results to scenario 1, start ignored, IMEM contents correct.
